// File: rtl/sq_pkg.sv
// rtl/sq_pkg.sv - shared widths, types and FSM states for the squarer column normaliser
package sq_pkg;
   localparam int DIGIT_W = 22;
   localparam int COL_W   = 23;
   localparam int CARRY_W = 2;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef logic [COL_W-1:0]   col_t;
   typedef logic [CARRY_W-1:0] carry_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_t;
endpackage

// File: rtl/sq_col_normalize_if.sv
// rtl/sq_col_normalize_if.sv - column-sum in / normalised-digit out handshake bundle
interface sq_col_normalize_if #(parameter int NUM_COLS = 8) ();
   import sq_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   col_t   [NUM_COLS-1:0]   col_sum;
   carry_t                  cin;
   logic                    out_valid;
   logic                    out_ready;
   digit_t [NUM_COLS-1:0]   digit;
   carry_t                  cout;

   modport slave (
      input  in_valid, col_sum, cin, out_ready,
      output in_ready, out_valid, digit, cout
   );

   modport master (
      output in_valid, col_sum, cin, out_ready,
      input  in_ready, out_valid, digit, cout
   );
endinterface

// File: rtl/sq_chunk_ripple.sv
// rtl/sq_chunk_ripple.sv - combinational carry ripple across one chunk of columns
module sq_chunk_ripple
   import sq_pkg::*;
#(
   parameter int COLS_PER_CYC = 2
) (
   input  col_t   [COLS_PER_CYC-1:0] col,
   input  carry_t                    cin,
   output digit_t [COLS_PER_CYC-1:0] digit,
   output carry_t                    cout
);
   localparam int SUM_W = COL_W + 1;

   carry_t c [COLS_PER_CYC+1];

   assign c[0] = cin;

   for (genvar j = 0; j < COLS_PER_CYC; j++) begin : g_col
      logic [SUM_W-1:0] t;
      // col <= 2^23-1 and carry <= 2 keeps t below 2^23+2, so the 2-bit carry is exact
      assign t        = {1'b0, col[j]} + {{(SUM_W-CARRY_W){1'b0}}, c[j]};
      assign digit[j] = t[DIGIT_W-1:0];
      assign c[j+1]   = t[SUM_W-1:DIGIT_W];
   end

   assign cout = c[COLS_PER_CYC];
endmodule

// File: rtl/sq_col_normalize.sv
// rtl/sq_col_normalize.sv - multi-cycle carry resolution of squarer column sums
// Accepts one vector, ripples COLS_PER_CYC columns per cycle, then holds the result.
module sq_col_normalize
   import sq_pkg::*;
#(
   parameter int NUM_COLS     = 8,
   parameter int COLS_PER_CYC = 2
) (
   input  logic              clk_sq,
   input  logic              reset_sq,
   sq_col_normalize_if.slave nrm
);
   localparam int P  = (COLS_PER_CYC < 1) ? 1 : NUM_COLS / COLS_PER_CYC;
   localparam int KW = (P > 1) ? $clog2(P) : 1;

   typedef logic [KW-1:0] k_t;
   localparam k_t K_LAST = k_t'(P - 1);

   if ((COLS_PER_CYC < 1) || (NUM_COLS % COLS_PER_CYC != 0)) begin : g_bad_params
      $error("sq_col_normalize: NUM_COLS must be a non-zero multiple of COLS_PER_CYC");
   end

   norm_state_t state_q, state_d;
   k_t          k_q, k_d;
   carry_t      carry_q, carry_d;
   carry_t      cout_q, cout_d;

   // Column and digit storage is viewed chunk-major so the counter indexes a whole chunk.
   col_t   [P-1:0][COLS_PER_CYC-1:0] cols_q, cols_d;
   digit_t [P-1:0][COLS_PER_CYC-1:0] digit_q, digit_d;

   col_t   [COLS_PER_CYC-1:0] chunk_cols;
   digit_t [COLS_PER_CYC-1:0] chunk_digits;
   carry_t                    chunk_cout;

   assign chunk_cols = cols_q[k_q];

   sq_chunk_ripple #(
      .COLS_PER_CYC (COLS_PER_CYC)
   ) u_ripple (
      .col   (chunk_cols),
      .cin   (carry_q),
      .digit (chunk_digits),
      .cout  (chunk_cout)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cols_d  = cols_q;
      digit_d = digit_q;
      case (state_q)
         IDLE: begin
            if (nrm.in_valid) begin
               cols_d  = nrm.col_sum;
               carry_d = nrm.cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            digit_d[k_q] = chunk_digits;
            carry_d      = chunk_cout;
            if (k_q == K_LAST) begin
               cout_d  = chunk_cout;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (nrm.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sq or negedge reset_sq) begin
      if (!reset_sq) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= '0;
         cout_q  <= '0;
         cols_q  <= '0;
         digit_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cols_q  <= cols_d;
         digit_q <= digit_d;
      end
   end

   assign nrm.in_ready  = (state_q == IDLE);
   assign nrm.out_valid = (state_q == DONE);
   assign nrm.digit     = digit_q;
   assign nrm.cout      = cout_q;
endmodule
